// File: rtl/icache_pkg.sv
// Shared constants, FSM state type and address field helpers for the
// direct-mapped instruction cache and its fill controller.
// Byte address layout: [ tag | index | word | byte ]. The byte bit is ignored
// because instructions are always 2-byte aligned.
package icache_pkg;

   localparam int unsigned ADDR_W          = 16;
   localparam int unsigned DATA_W          = 16;
   localparam int unsigned NUM_SETS        = 32;
   localparam int unsigned WORDS_PER_BLOCK = 8;

   localparam int unsigned INDEX_W  = $clog2(NUM_SETS);
   localparam int unsigned WORD_W   = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned OFFSET_W = WORD_W + 1;
   localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StCommit
   } fill_state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
      return addr[1 +: WORD_W];
   endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// Bus bundle for the instruction cache.
// Fetch side : fetch_req, fetch_addr, invalidate (requester -> cache),
//              fetch_instr, fetch_stall (cache -> requester).
// Memory side: mem_rd_req, mem_addr (cache -> memory),
//              mem_rd_valid, mem_rd_data (memory -> cache).
// The cache connects as fetch_slave and mem_master.
interface icache_fill_ctrl_if;
   import icache_pkg::*;

   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              invalidate;
   logic [DATA_W-1:0] fetch_instr;
   logic              fetch_stall;

   logic              mem_rd_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_valid;
   logic [DATA_W-1:0] mem_rd_data;

   modport fetch_slave (
      input  fetch_req, fetch_addr, invalidate,
      output fetch_instr, fetch_stall
   );

   modport fetch_master (
      output fetch_req, fetch_addr, invalidate,
      input  fetch_instr, fetch_stall
   );

   modport mem_master (
      output mem_rd_req, mem_addr,
      input  mem_rd_valid, mem_rd_data
   );

   modport mem_slave (
      input  mem_rd_req, mem_addr,
      output mem_rd_valid, mem_rd_data
   );

endinterface

// File: rtl/icache_data_array.sv
// Instruction cache data store: NumSets lines of WordsPerBlock words.
// Ports: clk_i; write port we_i/wr_index_i/wr_word_i/wr_data_i (synchronous);
//        read port rd_index_i/rd_word_i -> rd_data_o (combinational).
// Contents are not reset; the valid bits in the controller guard them.
module icache_data_array import icache_pkg::*; #(
   parameter int unsigned NumSets       = NUM_SETS,
   parameter int unsigned WordsPerBlock = WORDS_PER_BLOCK,
   parameter int unsigned DataW         = DATA_W
) (
   input  logic                             clk_i,
   input  logic                             we_i,
   input  logic [$clog2(NumSets)-1:0]       wr_index_i,
   input  logic [$clog2(WordsPerBlock)-1:0] wr_word_i,
   input  logic [DataW-1:0]                 wr_data_i,
   input  logic [$clog2(NumSets)-1:0]       rd_index_i,
   input  logic [$clog2(WordsPerBlock)-1:0] rd_word_i,
   output logic [DataW-1:0]                 rd_data_o
);

   localparam int unsigned IdxW  = $clog2(NumSets);
   localparam int unsigned WordW = $clog2(WordsPerBlock);

   logic [DataW-1:0]      mem_q [NumSets*WordsPerBlock];
   logic [IdxW+WordW-1:0] wr_addr;
   logic [IdxW+WordW-1:0] rd_addr;

   assign wr_addr   = {wr_index_i, wr_word_i};
   assign rd_addr   = {rd_index_i, rd_word_i};
   assign rd_data_o = mem_q[rd_addr];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_addr] <= wr_data_i;
      end
   end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a block-fill controller.
// Ports: clk, rst_n (async, active-low);
//        fetch (fetch_slave): combinational lookup, instruction + stall back;
//        mem (mem_master): one outstanding word read at a time during a fill.
// A miss stalls fetch, fills the whole line word-by-word, commits tag/valid
// in one extra cycle, and then the held fetch address is looked up again.
module icache_fill_ctrl import icache_pkg::*; (
   input  logic                    clk,
   input  logic                    rst_n,
   icache_fill_ctrl_if.fetch_slave fetch,
   icache_fill_ctrl_if.mem_master  mem
);

   fill_state_e state_q, state_d;

   logic [NUM_SETS-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q [NUM_SETS];
   logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
   logic [INDEX_W-1:0]  fill_index_q, fill_index_d;
   logic [WORD_W-1:0]   cnt_q, cnt_d;
   logic                inv_pend_q, inv_pend_d;

   logic                tag_we;
   logic                data_we;
   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [WORD_W-1:0]   req_word;
   logic [DATA_W-1:0]   rd_data;
   logic                hit;
   logic                miss;

   assign req_tag   = addr_tag(fetch.fetch_addr);
   assign req_index = addr_index(fetch.fetch_addr);
   assign req_word  = addr_word(fetch.fetch_addr);

   assign hit  = fetch.fetch_req & valid_q[req_index] & (tag_q[req_index] == req_tag);
   assign miss = fetch.fetch_req & ~hit;

   icache_data_array u_data (
      .clk_i      (clk),
      .we_i       (data_we),
      .wr_index_i (fill_index_q),
      .wr_word_i  (cnt_q),
      .wr_data_i  (mem.mem_rd_data),
      .rd_index_i (req_index),
      .rd_word_i  (req_word),
      .rd_data_o  (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         valid_q      <= '0;
         fill_tag_q   <= '0;
         fill_index_q <= '0;
         cnt_q        <= '0;
         inv_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         fill_tag_q   <= fill_tag_d;
         fill_index_q <= fill_index_d;
         cnt_q        <= cnt_d;
         inv_pend_q   <= inv_pend_d;
      end
   end

   // Tags need no reset: an entry is only consulted when its valid bit is set.
   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_q[fill_index_q] <= fill_tag_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      fill_tag_d   = fill_tag_q;
      fill_index_d = fill_index_q;
      cnt_d        = cnt_q;
      inv_pend_d   = inv_pend_q;
      tag_we       = 1'b0;
      data_we      = 1'b0;
      case (state_q)
         StIdle: begin
            // An invalidate (fresh or deferred from a fill) wins over a miss;
            // the miss is simply seen again on the next cycle.
            if (fetch.invalidate || inv_pend_q) begin
               valid_d    = '0;
               inv_pend_d = 1'b0;
            end else if (miss) begin
               state_d      = StFill;
               fill_tag_d   = req_tag;
               fill_index_d = req_index;
               cnt_d        = '0;
            end
         end
         StFill: begin
            if (fetch.invalidate) begin
               inv_pend_d = 1'b1;
            end
            if (mem.mem_rd_valid) begin
               data_we = 1'b1;
               if (cnt_q == WORD_W'(WORDS_PER_BLOCK - 1)) begin
                  state_d = StCommit;
               end else begin
                  cnt_d = cnt_q + WORD_W'(1);
               end
            end
         end
         StCommit: begin
            if (fetch.invalidate) begin
               inv_pend_d = 1'b1;
            end
            tag_we                = 1'b1;
            valid_d[fill_index_q] = 1'b1;
            cnt_d                 = '0;
            state_d               = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Stall and instruction are forced quiet while reset is held, even if the
   // requester keeps fetch_req high.
   always_comb begin
      mem.mem_rd_req    = (state_q == StFill);
      mem.mem_addr      = '0;
      if (state_q == StFill) begin
         mem.mem_addr = {fill_tag_q, fill_index_q, cnt_q, 1'b0};
      end
      fetch.fetch_stall = rst_n & (miss | (state_q != StIdle));
      fetch.fetch_instr = '0;
      if (rst_n && fetch.fetch_req && !fetch.fetch_stall) begin
         fetch.fetch_instr = rd_data;
      end
   end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
module tb_icache_fill_ctrl;
   import icache_pkg::*;

   localparam int Wpb = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   icache_fill_ctrl_if bus ();

   icache_fill_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fetch (bus),
      .mem   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Memory responder settings and log of words it has returned.
   int          mem_lat  = 1;
   bit          noise_en = 1'b0;
   logic [15:0] mem_log[$];

   // Reference model: which block each set holds.
   bit model_valid[32];
   int model_tag[32];

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      return 16'hA000 + (a >> 1);
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < 32; s++) model_valid[s] = 1'b0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory: answers the held request after mem_lat cycles; when idle it
   // occasionally pulses a stray mem_rd_valid that the cache must ignore.
   initial begin
      int wcnt;
      wcnt = 0;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_rd_valid = 1'b0;
         bus.mem_rd_data  = '0;
         if (bus.mem_rd_req) begin
            wcnt++;
            if (wcnt >= mem_lat) begin
               bus.mem_rd_valid = 1'b1;
               bus.mem_rd_data  = mem_val(bus.mem_addr);
               mem_log.push_back(bus.mem_addr);
               wcnt = 0;
            end
         end else begin
            wcnt = 0;
            if (noise_en && $urandom_range(0, 7) == 0) begin
               bus.mem_rd_valid = 1'b1;
               bus.mem_rd_data  = 16'($urandom);
            end
         end
      end
   end

   // One fetch until the instruction is delivered. inv_at >= 0 pulses
   // invalidate during the stall cycle with that index (0 = the miss cycle).
   task automatic fetch(input logic [15:0] a, input int lat, input int inv_at);
      int idx, tag, n, exp_stall;
      bit hit;
      idx = (a >> 4) % 32;
      tag = a >> 9;
      if (inv_at == 0) model_clear();
      hit = model_valid[idx] && (model_tag[idx] == tag);
      exp_stall = hit ? 0 : 2 + Wpb * lat + ((inv_at == 0) ? 1 : 0);
      mem_lat = lat;
      mem_log.delete();
      @(posedge clk);
      #1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      n = 0;
      forever begin
         @(negedge clk);
         bus.invalidate = 1'b0;
         if (!bus.fetch_stall) break;
         if (n == inv_at) bus.invalidate = 1'b1;
         n++;
         if (n > 400) begin
            check_eq("stall_bound", 32'(n), 32'd0);
            break;
         end
      end
      check_eq("stall_cycles", 32'(n), 32'(exp_stall));
      check_eq("instr", 32'(bus.fetch_instr), 32'(mem_val(a)));
      check_eq("rd_req_on_hit", 32'(bus.mem_rd_req), 32'd0);
      if (!hit) begin
         check_eq("fill_words", 32'(mem_log.size()), 32'(Wpb));
         for (int k = 0; k < Wpb && k < mem_log.size(); k++) begin
            check_eq("fill_addr", 32'(mem_log[k]), 32'((a & 16'hFFF0) + 2 * k));
         end
         model_valid[idx] = 1'b1;
         model_tag[idx]   = tag;
         if (inv_at > 0) model_clear();
      end else begin
         check_eq("hit_no_mem", 32'(mem_log.size()), 32'd0);
      end
   endtask

   // Processor halted: fetch_req low with a random address.
   task automatic halt(input int n, input bit inv);
      @(posedge clk);
      #1;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = 16'($urandom);
      bus.invalidate = inv;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_eq("halt_stall", 32'(bus.fetch_stall), 32'd0);
         check_eq("halt_rd_req", 32'(bus.mem_rd_req), 32'd0);
         check_eq("halt_instr", 32'(bus.fetch_instr), 32'd0);
         @(posedge clk);
         #1;
         bus.invalidate = 1'b0;
         bus.fetch_addr = 16'($urandom);
      end
      if (inv) model_clear();
   endtask

   initial begin
      int n;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.invalidate = 1'b0;
      model_clear();

      // Reset state, including with a request pending.
      #22;
      check_eq("rst_rd_req", 32'(bus.mem_rd_req), 32'd0);
      check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      bus.fetch_req = 1'b1;
      #1;
      check_eq("rst_stall", 32'(bus.fetch_stall), 32'd0);
      check_eq("rst_instr", 32'(bus.fetch_instr), 32'd0);
      bus.fetch_req = 1'b0;
      #7;
      rst_n    = 1'b1;
      noise_en = 1'b1;

      // Cold miss, then same-line hits.
      fetch(16'h0000, 3, -1);
      for (int w = 1; w < Wpb; w++) fetch(16'(2 * w), 1, -1);

      // Conflict eviction in set 0.
      fetch(16'h0200, 2, -1);
      fetch(16'h0000, 1, -1);

      // Redirect mid-fill: latched block completes, then the new one fills.
      mem_lat = 2;
      mem_log.delete();
      @(posedge clk);
      #1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 16'h0040;
      n = 0;
      while (mem_log.size() < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      bus.fetch_addr = 16'h0100;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.fetch_stall && n < 400);
      check_eq("redir_stall", 32'(bus.fetch_stall), 32'd0);
      check_eq("redir_words", 32'(mem_log.size()), 32'(2 * Wpb));
      for (int k = 0; k < 2 * Wpb && k < mem_log.size(); k++) begin
         check_eq("redir_addr", 32'(mem_log[k]),
                  (k < Wpb) ? 32'(16'h0040 + 2 * k) : 32'(16'h0100 + 2 * (k - Wpb)));
      end
      check_eq("redir_instr", 32'(bus.fetch_instr), 32'(mem_val(16'h0100)));
      model_valid[4]  = 1'b1;
      model_tag[4]    = 0;
      model_valid[16] = 1'b1;
      model_tag[16]   = 0;
      fetch(16'h0040, 1, -1);
      fetch(16'h0102, 1, -1);

      // Asynchronous reset at word 5 of a fill.
      mem_lat = 2;
      mem_log.delete();
      @(posedge clk);
      #1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 16'h0440;
      n = 0;
      while (mem_log.size() < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("pre_rst_rd_req", 32'(bus.mem_rd_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_rd_req", 32'(bus.mem_rd_req), 32'd0);
      check_eq("midrst_stall", 32'(bus.fetch_stall), 32'd0);
      check_eq("midrst_instr", 32'(bus.fetch_instr), 32'd0);
      check_eq("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
      bus.fetch_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      fetch(16'h0040, 1, -1);
      fetch(16'h0446, 1, -1);

      // Invalidate during a fill: the freshly filled line is dropped too.
      fetch(16'h0300, 2, 7);
      fetch(16'h0302, 1, -1);
      fetch(16'h0040, 1, -1);

      // Halt with invalidate in idle, then invalidate together with a miss.
      halt(3, 1'b0);
      halt(1, 1'b1);
      fetch(16'h0040, 1, -1);
      fetch(16'h0500, 1, 0);

      // Random traffic over a few conflicting sets.
      for (int it = 0; it < 60; it++) begin
         logic [15:0] a;
         int lat, inv_at;
         a = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4) |
                 ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
         lat = $urandom_range(1, 4);
         inv_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, Wpb * lat) : -1;
         fetch(a, lat, inv_at);
         if ($urandom_range(0, 3) == 0) halt($urandom_range(1, 3), $urandom_range(0, 3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
